// File: rtl/neuron_pkg.sv
// Shared fixed-point types and loader FSM encoding for the neuron datapath.
package neuron_pkg;
   localparam int PRECISION = 16;
   localparam int FRAC      = 10;

   typedef logic signed [PRECISION-1:0] fixed_t;

   localparam fixed_t FX_ONE  = 16'sh0400;
   localparam fixed_t FX_ZERO = '0;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } ldr_state_t;
endpackage

// File: rtl/vec_out_reg.sv
// Output register bank for one assembled frame plus the out_valid/out_ready bookkeeping.
module vec_out_reg #(
   parameter int N = 4,
   parameter int W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [N-1:0][W-1:0]   load_x_i,
   input  logic [N-1:0][W-1:0]   load_w_i,
   input  logic [W-1:0]          load_bias_i,
   input  logic                  out_ready_i,
   output logic                  can_load_o,
   output logic                  out_valid_o,
   output logic [N-1:0][W-1:0]   x_o,
   output logic [N-1:0][W-1:0]   weights_o,
   output logic [W-1:0]          bias_o
);
   logic                out_valid_q;
   logic [N-1:0][W-1:0] x_q;
   logic [N-1:0][W-1:0] w_q;
   logic [W-1:0]        bias_q;

   // A frame may be replaced in the same edge it is consumed, so valid never bubbles.
   assign can_load_o = !out_valid_q || out_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         x_q         <= '0;
         w_q         <= '0;
         bias_q      <= '0;
      end else if (load_i) begin
         out_valid_q <= 1'b1;
         x_q         <= load_x_i;
         w_q         <= load_w_i;
         bias_q      <= load_bias_i;
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid_o = out_valid_q;
   assign x_o         = x_q;
   assign weights_o   = w_q;
   assign bias_o      = bias_q;
endmodule

// File: rtl/neuron_input_loader.sv
// Assembles N serial (x, weight) beats plus a frame bias into a double-buffered vector frame.
module neuron_input_loader
   import neuron_pkg::*;
#(
   parameter int N         = 4,
   parameter int precision = PRECISION,
   parameter int FRAC      = neuron_pkg::FRAC
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [precision-1:0]          in_x,
   input  logic [precision-1:0]          in_w,
   input  logic [precision-1:0]          in_bias,
   input  logic                          in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N-1:0][precision-1:0]   x,
   output logic [N-1:0][precision-1:0]   weights,
   output logic [precision-1:0]          bias,
   output logic                          err_frame,
   output ldr_state_t                    dbg_state_o,
   output logic [$clog2(N)-1:0]          dbg_idx_o
);
   localparam int IW = $clog2(N);

   // Handshakes: a beat/frame transfers on a rising edge where valid and ready are both 1;
   // valid holds its payload stable until that edge, ready may change freely.
   ldr_state_t                  state_q;
   logic [IW-1:0]               idx_q, idx_d;
   logic                        err_q;
   logic [N-1:0][precision-1:0] fill_x_q, fill_w_q;
   logic [precision-1:0]        fill_bias_q;

   logic                        accept, last_slot, malformed, complete;
   logic                        can_load, load;
   logic [N-1:0][precision-1:0] load_x, load_w;

   assign in_ready  = (state_q == FILL);
   assign accept    = in_valid && in_ready;
   assign last_slot = (idx_q == IW'(N - 1));
   assign malformed = accept && (in_last != last_slot);
   assign complete  = accept && last_slot && in_last;
   assign load      = can_load && (complete || (state_q == HOLD));

   // The completing beat is forwarded straight into the output bank so latency is one edge.
   always_comb begin
      load_x = fill_x_q;
      load_w = fill_w_q;
      if (state_q == FILL) begin
         load_x[N-1] = in_x;
         load_w[N-1] = in_w;
      end
   end

   always_comb begin
      idx_d = idx_q;
      if (accept) begin
         idx_d = (malformed || last_slot) ? '0 : idx_q + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         idx_q       <= '0;
         err_q       <= 1'b0;
         fill_x_q    <= '0;
         fill_w_q    <= '0;
         fill_bias_q <= '0;
      end else begin
         err_q <= malformed;
         idx_q <= idx_d;
         if (accept) begin
            fill_x_q[idx_q] <= in_x;
            fill_w_q[idx_q] <= in_w;
            if (idx_q == '0) fill_bias_q <= in_bias;
         end
         case (state_q)
            FILL:    if (complete && !can_load) state_q <= HOLD;
            HOLD:    if (can_load) state_q <= FILL;
            default: state_q <= FILL;
         endcase
      end
   end

   vec_out_reg #(.N(N), .W(precision)) u_out (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load),
      .load_x_i    (load_x),
      .load_w_i    (load_w),
      .load_bias_i (fill_bias_q),
      .out_ready_i (out_ready),
      .can_load_o  (can_load),
      .out_valid_o (out_valid),
      .x_o         (x),
      .weights_o   (weights),
      .bias_o      (bias)
   );

   assign err_frame   = err_q;
   assign dbg_state_o = state_q;
   assign dbg_idx_o   = idx_q;
endmodule

// File: tb/tb_neuron_input_loader.sv
// Directed, table-driven bench for neuron_input_loader with hand-computed neuron results.
module tb_neuron_input_loader;
  import neuron_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_x, in_w, in_bias;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [3:0][15:0]  x, weights;
  logic [15:0]       bias;
  logic              err_frame;
  ldr_state_t        dbg_state;
  logic [1:0]        dbg_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0][15:0] x;
    logic [3:0][15:0] w;
    logic [15:0]      bias;
    int               nbeats;
    int               last_beat;
    bit               exp_err;
    logic [15:0]      exp_neuron;
  } frame_t;

  frame_t tbl[6];

  neuron_input_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_w        (in_w),
    .in_bias     (in_bias),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .x           (x),
    .weights     (weights),
    .bias        (bias),
    .err_frame   (err_frame),
    .dbg_state_o (dbg_state),
    .dbg_idx_o   (dbg_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Q6.10 reference neuron: sum(x*w) >> FRAC + bias, truncated to 16 bits.
  function automatic logic [15:0] neuron(input logic [3:0][15:0] vx, input logic [3:0][15:0] vw,
                                         input logic [15:0] vb);
    longint acc = 0;
    for (int i = 0; i < 4; i++) acc += longint'($signed(vx[i])) * longint'($signed(vw[i]));
    acc = (acc >>> 10) + longint'($signed(vb));
    return acc[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive all beats of a frame; in_bias is junk on beats other than 0
  task automatic send_frame(input frame_t f, input bit keep_valid, input bit ready_on_last);
    for (int b = 0; b < f.nbeats; b++) begin
      in_valid = 1'b1;
      in_x     = f.x[b];
      in_w     = f.w[b];
      in_bias  = (b == 0) ? f.bias : 16'h7777;
      in_last  = (b == f.last_beat);
      if (ready_on_last && b == f.nbeats - 1) out_ready = 1'b1;
      chk("in_ready_beat", {63'd0, in_ready}, 64'd1);
      tick();
    end
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{x: {16'h0800, 16'h0400, 16'h0400, 16'h0400}, w: {16'h0400, 16'h0400, 16'h0800, 16'h0400},
               bias: 16'h0001, nbeats: 4, last_beat: 3, exp_err: 1'b0, exp_neuron: 16'h1801};
    tbl[1] = '{x: {16'h0800, 16'h0400, 16'h0200, 16'h0400}, w: {16'h0400, 16'h0400, 16'h0800, 16'h0700},
               bias: 16'h0003, nbeats: 4, last_beat: 3, exp_err: 1'b0, exp_neuron: 16'h1703};
    tbl[2] = '{x: {16'h0, 16'h0, 16'h1111, 16'h2222}, w: {16'h0, 16'h0, 16'h3333, 16'h4444},
               bias: 16'h0009, nbeats: 2, last_beat: 1, exp_err: 1'b1, exp_neuron: 16'h0};
    tbl[3] = '{x: {16'h0000, 16'hfc00, 16'h0400, 16'h0800}, w: {16'h0400, 16'h0400, 16'h0400, 16'h0400},
               bias: 16'h0005, nbeats: 4, last_beat: 3, exp_err: 1'b0, exp_neuron: 16'h0805};
    tbl[4] = '{x: {16'h5555, 16'h6666, 16'h7777, 16'h1234}, w: {16'h1, 16'h2, 16'h3, 16'h4},
               bias: 16'h000a, nbeats: 4, last_beat: -1, exp_err: 1'b1, exp_neuron: 16'h0};
    tbl[5] = '{x: {16'h0200, 16'h0200, 16'h0200, 16'h0200}, w: {16'h0800, 16'h0800, 16'h0800, 16'h0800},
               bias: 16'hfff0, nbeats: 4, last_beat: 3, exp_err: 1'b0, exp_neuron: 16'h0ff0};

    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_w = '0; in_bias = '0; in_last = 1'b0; out_ready = 1'b1;
    #12 rst_n = 1'b1;
    tick();

    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_x", x, 64'd0);
    chk("rst_weights", weights, 64'd0);
    chk("rst_bias", {48'd0, bias}, 64'd0);
    chk("rst_err", {63'd0, err_frame}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_state", {63'd0, dbg_state}, {63'd0, FILL});
    chk("rst_idx", {62'd0, dbg_idx}, 64'd0);

    // table: isolated frames with downstream always ready
    for (int t = 0; t < 6; t++) begin
      send_frame(tbl[t], 1'b0, 1'b0);
      if (!tbl[t].exp_err) begin
        chk("tbl_out_valid", {63'd0, out_valid}, 64'd1);
        chk("tbl_x", x, tbl[t].x);
        chk("tbl_weights", weights, tbl[t].w);
        chk("tbl_bias", {48'd0, bias}, {48'd0, tbl[t].bias});
        chk("tbl_neuron", {48'd0, neuron(x, weights, bias)}, {48'd0, tbl[t].exp_neuron});
        chk("tbl_no_err", {63'd0, err_frame}, 64'd0);
        tick();
        chk("tbl_consumed", {63'd0, out_valid}, 64'd0);
        chk("tbl_data_kept", x, tbl[t].x);
      end else begin
        chk("tbl_err_pulse", {63'd0, err_frame}, 64'd1);
        chk("tbl_err_no_valid", {63'd0, out_valid}, 64'd0);
        chk("tbl_err_idx", {62'd0, dbg_idx}, 64'd0);
        tick();
        chk("tbl_err_one_cycle", {63'd0, err_frame}, 64'd0);
        chk("tbl_err_still_no_valid", {63'd0, out_valid}, 64'd0);
      end
      tick();
    end

    // back-to-back frames, in_valid held high
    send_frame(tbl[0], 1'b1, 1'b0);
    chk("b2b_f0_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b_f0_neuron", {48'd0, neuron(x, weights, bias)}, 64'h1801);
    send_frame(tbl[1], 1'b0, 1'b0);
    chk("b2b_f1_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b_f1_neuron", {48'd0, neuron(x, weights, bias)}, 64'h1703);
    chk("b2b_f1_x", x, tbl[1].x);
    tick();
    tick();

    // backpressure: frame 2 completes while frame 1 is still held
    send_frame(tbl[0], 1'b0, 1'b0);
    out_ready = 1'b0;
    send_frame(tbl[1], 1'b0, 1'b0);
    chk("bp_state_hold", {63'd0, dbg_state}, {63'd0, HOLD});
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
    chk("bp_f1_kept", {48'd0, neuron(x, weights, bias)}, 64'h1801);
    in_valid = 1'b1; in_x = 16'h1234; in_w = 16'h4321; in_last = 1'b0;
    tick();
    chk("bp_beat_refused_idx", {62'd0, dbg_idx}, 64'd0);
    chk("bp_still_hold", {63'd0, dbg_state}, {63'd0, HOLD});
    chk("bp_f1_still_kept", x, tbl[0].x);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_f2_loaded", {48'd0, neuron(x, weights, bias)}, 64'h1703);
    chk("bp_f2_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_state_fill", {63'd0, dbg_state}, {63'd0, FILL});
    chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);

    // simultaneous consume and complete: ready rises on the completing beat
    out_ready = 1'b0;
    send_frame(tbl[3], 1'b0, 1'b1);
    chk("sim_valid_no_bubble", {63'd0, out_valid}, 64'd1);
    chk("sim_new_frame", {48'd0, neuron(x, weights, bias)}, 64'h0805);
    chk("sim_state_fill", {63'd0, dbg_state}, {63'd0, FILL});

    // reset mid-frame with a frame still held at the output
    out_ready = 1'b0;
    in_valid = 1'b1; in_last = 1'b0; in_x = 16'h0abc; in_w = 16'h0def; in_bias = 16'h0fff;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_x", x, 64'd0);
    chk("mrst_weights", weights, 64'd0);
    chk("mrst_bias", {48'd0, bias}, 64'd0);
    chk("mrst_idx", {62'd0, dbg_idx}, 64'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send_frame(tbl[5], 1'b0, 1'b0);
    chk("mrst_frame_valid", {63'd0, out_valid}, 64'd1);
    chk("mrst_frame_x", x, tbl[5].x);
    chk("mrst_frame_w", weights, tbl[5].w);
    chk("mrst_frame_neuron", {48'd0, neuron(x, weights, bias)}, 64'h0ff0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
